// File: rtl/muldiv_pkg.sv
// Shared types for the HI/LO multiply/divide resource: opcode and sequencer state encodings.
package muldiv_pkg;

  localparam int unsigned MULDIV_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_DIV   = 2'd0,
    OP_DIVU  = 2'd1,
    OP_MULT  = 2'd2,
    OP_MULTU = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PREP  = 2'd1,
    ITER  = 2'd2,
    FIXUP = 2'd3
  } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the sequencer: restoring-divide step on {rem, quo} or shift-add step on the product.
module muldiv_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               is_div_i,
  input  logic [WIDTH-1:0]   operand_i,
  input  logic [2*WIDTH-1:0] acc_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0] rem_ext;
  logic [WIDTH:0] rem_diff;
  logic [WIDTH:0] sum;

  always_comb begin
    rem_ext  = acc_i[2*WIDTH-1:WIDTH-1];
    rem_diff = rem_ext - {1'b0, operand_i};
    sum      = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, (acc_i[0] ? operand_i : '0)};
    acc_o    = '0;
    if (is_div_i) begin
      // Remainder needs WIDTH+1 bits after the shift; it fits back in WIDTH once reduced.
      if (rem_ext >= {1'b0, operand_i}) begin
        acc_o = {rem_diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_o = {rem_ext[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_o = {sum, acc_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative DIV/DIVU/MULT/MULTU sequencer writing HI/LO with MFHI/MFLO interlock.
// MULDIV_MULT_EN: when defined, MULT/MULTU are sequenced; otherwise they are ignored.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MULDIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  op_t              op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             rd_hi,
  input  logic             rd_lo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             stall
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  state_t             state_q, state_d;
  op_t                op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               neg_lo_q, neg_lo_d;
  logic               neg_hi_q, neg_hi_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               dz_q, dz_d;

  logic               is_div_op;
  logic               is_signed;
  logic               accept;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] step_acc;

  assign is_div_op = (op_q == OP_DIV) || (op_q == OP_DIVU);
  assign is_signed = (op_q == OP_DIV) || (op_q == OP_MULT);
  assign a_neg     = is_signed && a_q[WIDTH-1];
  assign b_neg     = is_signed && b_q[WIDTH-1];
  assign a_mag     = a_neg ? -a_q : a_q;
  assign b_mag     = b_neg ? -b_q : b_q;

`ifdef MULDIV_MULT_EN
  assign accept = start;
`else
  assign accept = start && ((op == OP_DIV) || (op == OP_DIVU));
`endif

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div_i  (is_div_op),
    .operand_i (opnd_q),
    .acc_i     (acc_q),
    .acc_o     (step_acc)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dz_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d    = op;
          a_d     = src_a;
          b_d     = src_b;
          state_d = PREP;
        end
      end
      PREP: begin
        cnt_d = '0;
        acc_d = '0;
        if (is_div_op) begin
          acc_d    = {{WIDTH{1'b0}}, a_mag};
          opnd_d   = b_mag;
          neg_lo_d = a_neg ^ b_neg;
          neg_hi_d = a_neg;
          state_d  = (b_q == '0) ? FIXUP : ITER;
        end
`ifdef MULDIV_MULT_EN
        else begin
          // Multiplier rides in the low half and is consumed as the product shifts in.
          acc_d    = {{WIDTH{1'b0}}, b_mag};
          opnd_d   = a_mag;
          neg_lo_d = a_neg ^ b_neg;
          neg_hi_d = a_neg ^ b_neg;
          state_d  = ITER;
        end
`endif
      end
      ITER: begin
        acc_d = step_acc;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = FIXUP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FIXUP: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (is_div_op) begin
          if (b_q == '0) begin
            hi_d = a_q;
            lo_d = '1;
            dz_d = 1'b1;
          end else begin
            hi_d = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
            lo_d = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
          end
        end
`ifdef MULDIV_MULT_EN
        else begin
          {hi_d, lo_d} = neg_lo_q ? -acc_q : acc_q;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= OP_DIV;
      a_q      <= '0;
      b_q      <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign div_zero = dz_q;
  assign stall    = busy && (start || rd_hi || rd_lo);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed table, corner sequences and random ops vs. an arithmetic model.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  op_t         op = OP_DIV;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        rd_hi = 1'b0;
  logic        rd_lo = 1'b0;
  logic [31:0] hi, lo;
  logic        busy, done, div_zero, stall;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;

  always #5 clk = ~clk;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .rd_hi(rd_hi), .rd_lo(rd_lo),
    .hi(hi), .lo(lo), .busy(busy), .done(done),
    .div_zero(div_zero), .stall(stall)
  );

  typedef struct {
    op_t         op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          cyc;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Architectural result from plain 64-bit arithmetic.
  function automatic void ref_model(input op_t o, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] rhi, output logic [31:0] rlo,
                                    output logic rdz, output int cyc, output bit ign);
    longint      sa, sb, q, r, ps;
    logic [63:0] pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    rdz = 1'b0; cyc = 34; ign = 1'b0; rhi = '0; rlo = '0;
    if ((o == OP_DIV || o == OP_DIVU) && b == 32'd0) begin
      rhi = a; rlo = 32'hFFFF_FFFF; rdz = 1'b1; cyc = 2;
    end else begin
      case (o)
        OP_DIV: begin
          q = sa / sb; r = sa % sb;
          rlo = q[31:0]; rhi = r[31:0];
        end
        OP_DIVU: begin
          rlo = a / b; rhi = a % b;
        end
        OP_MULT: begin
          ps = sa * sb;
          {rhi, rlo} = ps;
        end
        default: begin
          pu = {32'd0, a} * {32'd0, b};
          {rhi, rlo} = pu;
        end
      endcase
    end
`ifndef MULDIV_MULT_EN
    if (o == OP_MULT || o == OP_MULTU) ign = 1'b1;
`endif
  endfunction

  // Called just after a negedge; returns just after a negedge.
  task automatic run_op(input op_t o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input logic edz,
                        input int ecyc, input string tag);
    int cyc;
    bit got;
    op = o; src_a = a; src_b = b; start = 1'b1;
    #1 chk({tag, ".stall_idle"}, 64'(stall), 64'(0));
    @(posedge clk); #1 start = 1'b0;
    cyc = 0; got = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin got = 1; break; end
      if (busy) cyc++;
    end
    chk({tag, ".done_seen"}, 64'(got), 64'(1));
    chk({tag, ".busy_cycles"}, 64'(cyc), 64'(ecyc));
    chk({tag, ".hi"}, 64'(hi), 64'(ehi));
    chk({tag, ".lo"}, 64'(lo), 64'(elo));
    chk({tag, ".div_zero"}, 64'(div_zero), 64'(edz));
    @(negedge clk);
    chk({tag, ".done_once"}, 64'(done), 64'(0));
    last_hi = ehi; last_lo = elo;
  endtask

  task automatic run_ignored(input op_t o, input logic [31:0] a, input logic [31:0] b, input string tag);
    op = o; src_a = a; src_b = b; start = 1'b1;
    #1 chk({tag, ".stall"}, 64'(stall), 64'(0));
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk({tag, ".busy"}, 64'(busy), 64'(0));
      chk({tag, ".done"}, 64'(done), 64'(0));
    end
    chk({tag, ".hi"}, 64'(hi), 64'(last_hi));
    chk({tag, ".lo"}, 64'(lo), 64'(last_lo));
  endtask

  task automatic apply(input op_t o, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] ehi, elo;
    logic edz;
    int ecyc;
    bit ign;
    ref_model(o, a, b, ehi, elo, edz, ecyc, ign);
    if (ign) run_ignored(o, a, b, tag);
    else     run_op(o, a, b, ehi, elo, edz, ecyc, tag);
  endtask

  vec_t tbl[8];

  initial begin
    int cyc;
    bit got;
    logic [31:0] ra, rb;
    op_t ro;

    tbl[0] = '{OP_DIVU, 32'd100,        32'd7,          32'd2,          32'd14,         1'b0, 34};
    tbl[1] = '{OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  32'hFFFF_FFFD,  1'b0, 34};
    tbl[2] = '{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0, 34};
    tbl[3] = '{OP_DIV,  32'd5,          32'd0,          32'd5,          32'hFFFF_FFFF,  1'b1, 2};
    tbl[4] = '{OP_DIV,  32'd7,          32'hFFFF_FFFE,  32'd1,          32'hFFFF_FFFD,  1'b0, 34};
    tbl[5] = '{OP_DIVU, 32'hFFFF_FFFF,  32'd1,          32'd0,          32'hFFFF_FFFF,  1'b0, 34};
    tbl[6] = '{OP_DIVU, 32'd3,          32'hFFFF_FFFF,  32'd3,          32'd0,          1'b0, 34};
    tbl[7] = '{OP_DIV,  32'hFFFF_FFFF,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1, 2};

    repeat (2) @(negedge clk);
    chk("reset.hi", 64'(hi), 64'(0));
    chk("reset.lo", 64'(lo), 64'(0));
    chk("reset.busy", 64'(busy), 64'(0));
    chk("reset.done", 64'(done), 64'(0));
    chk("reset.div_zero", 64'(div_zero), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++)
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, tbl[i].dz, tbl[i].cyc,
             $sformatf("tbl%0d", i));

`ifdef MULDIV_MULT_EN
    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 34, "mult_neg");
`else
    run_ignored(OP_MULT, 32'hFFFF_FFFD, 32'd5, "mult_off");
`endif

    // Held MFHI plus a second start queued behind the first operation.
    op = OP_DIVU; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    src_a = 32'd9; src_b = 32'd3; rd_hi = 1'b1;
    got = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin got = 1; break; end
      chk("stall.held", 64'(stall), 64'(1));
    end
    chk("stall.done_seen", 64'(got), 64'(1));
    chk("stall.release", 64'(stall), 64'(0));
    chk("stall.hi_new", 64'(hi), 64'(2));
    chk("stall.lo_new", 64'(lo), 64'(14));
    @(posedge clk); #1 start = 1'b0; rd_hi = 1'b0;
    @(negedge clk);
    chk("second.accepted", 64'(busy), 64'(1));
    cyc = 1; got = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin got = 1; break; end
      if (busy) cyc++;
    end
    chk("second.done_seen", 64'(got), 64'(1));
    chk("second.busy_cycles", 64'(cyc), 64'(34));
    chk("second.lo", 64'(lo), 64'(3));
    chk("second.hi", 64'(hi), 64'(0));
    @(negedge clk);
    last_hi = 32'd0; last_lo = 32'd3;

    // Asynchronous reset in the middle of the iteration loop.
    op = OP_DIVU; src_a = 32'd1000; src_b = 32'd3; start = 1'b1;
    @(posedge clk); #1 start = 1'b0; rd_lo = 1'b1;
    repeat (12) @(negedge clk);
    chk("midrst.busy_before", 64'(busy), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("midrst.busy", 64'(busy), 64'(0));
    chk("midrst.hi", 64'(hi), 64'(0));
    chk("midrst.lo", 64'(lo), 64'(0));
    chk("midrst.done", 64'(done), 64'(0));
    chk("midrst.stall", 64'(stall), 64'(0));
    @(negedge clk);
    rst_n = 1'b1; rd_lo = 1'b0;
    last_hi = '0; last_lo = '0;
    @(negedge clk);
    run_op(OP_DIVU, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0, 34, "after_rst");

    for (int i = 0; i < 40; i++) begin
      ro = op_t'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       ra = $urandom_range(0, 1000);
        1:       ra = 32'h8000_0000;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = $urandom_range(1, 20);
        default: rb = $urandom;
      endcase
      apply(ro, ra, rb, $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle sequencer for the HI/LO multiply/divide resource of the MIPS core. It accepts DIV/DIVU/MULT/MULTU requests from the control unit and runs a WIDTH-step iterative shift-subtract or shift-add loop. It writes HI/LO and interlocks MFHI/MFLO (and back-to-back requests) by raising `stall` to the PC/register-write path while a result is pending.

## Interface
Parameters:
- `WIDTH`, 32: operand width; HI and LO are each WIDTH bits.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  valid muldiv instruction decoded this cycle.
- `op`  in  2  `muldiv_pkg::op_t`: 0 = DIV, 1 = DIVU, 2 = MULT, 3 = MULTU.
- `src_a`  in  WIDTH  rs value (dividend / multiplicand).
- `src_b`  in  WIDTH  rt value (divisor / multiplier).
- `rd_hi`, `rd_lo`  in  1 each  MFHI / MFLO decoded this cycle.
- `hi`, `lo`  out  WIDTH each  architectural HI/LO registers.
- `busy`  out  1  state != IDLE.
- `done`  out  1  one-cycle pulse; HI/LO were updated on the previous edge.
- `div_zero`  out  1  one-cycle pulse coincident with `done` for a division by zero.
- `stall`  out  1  combinational: `busy && (start || rd_hi || rd_lo)`.

## Operation
- States: IDLE, PREP, ITER, FIXUP.
- IDLE:
  - `start` = 1 latches `op`, `src_a`, `src_b` and goes to PREP.
  - `start` while busy is not accepted. `stall` holds the instruction until IDLE, and it is accepted on that cycle.
- PREP:
  - Signed ops take absolute values and record the result signs:
    - quotient negative when the operand signs differ;
    - remainder takes the sign of the dividend;
    - product negative when the operand signs differ.
  - Clears the counter and accumulator.
  - DIV/DIVU with `src_b` = 0 goes directly to FIXUP. Otherwise goes to ITER.
- ITER:
  - Exactly WIDTH steps, counter 0..WIDTH-1 with width clog2(WIDTH)+1.
  - Divide step: restoring; shift {rem, quo} left 1; if rem >= divisor, subtract and set the quotient LSB.
  - Multiply step: if the multiplier LSB is 1, add the multiplicand to the upper half of the 2*WIDTH accumulator, then shift right 1.
  - Goes to FIXUP after step WIDTH-1.
- FIXUP:
  - Applies two's-complement sign correction.
  - Writes HI = remainder / product[2W-1:W] and LO = quotient / product[W-1:0].
  - Goes to IDLE.
- Division by zero: HI = dividend (unmodified `src_a`), LO = all ones, `div_zero` pulses.
- Signed overflow (min_int / -1): LO = min_int, HI = 0. This falls out of unsigned magnitude arithmetic and needs no special case.
- HI/LO hold their value between operations and change only in FIXUP.

## Timing
- Edge E0 samples `start`.
- Normal path:
  - E1 enters ITER.
  - E1+WIDTH enters FIXUP.
  - E2+WIDTH writes HI/LO and returns to IDLE.
  - `done` is high in the cycle after E2+WIDTH.
- Total latency is WIDTH+2 edges (34 for WIDTH = 32). `busy` is high for WIDTH+2 cycles.
- Divide by zero: writes on E2; `busy` is high for 2 cycles.
- An MFHI/MFLO issued during busy stalls and reads the new value in the `done` cycle. `stall` is low in that cycle.
- A new `start` may be accepted in the `done` cycle.
- Reset (asynchronous, also mid-ITER):
  - state = IDLE, counter and accumulator 0;
  - `hi` = 0, `lo` = 0;
  - `busy`, `done`, `div_zero`, `stall` = 0.
  - No partial result is written.

## Configuration
- `MULDIV_MULT_EN`:
  - Defined: MULT/MULTU are sequenced as above.
  - Undefined: the multiply path is not compiled. `start` with op 2/3 is ignored: state stays IDLE, HI/LO are unchanged, `stall` and `busy` stay 0. DIV/DIVU are unaffected.

## Structure
- `muldiv_pkg` holds:
  - `op_t` (2-bit enum);
  - `state_t` (IDLE, PREP, ITER, FIXUP);
  - default WIDTH constant `MULDIV_WIDTH` = 32.
- The control unit imports `op_t` to drive `op` from `funct`.
- One sub-module, `muldiv_step`: combinational single iteration (restoring-divide step or shift-add step selected by an is_div input), instantiated once inside ITER.

## Test plan
- DIVU 100 / 7: `busy` high for 34 cycles; then LO = 14, HI = 2, `done` pulses once.
- DIV -7 / 2: LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- DIV 5 / 0: `done` and `div_zero` both pulse 2 cycles after start; HI = 5, LO = 0xFFFFFFFF.
- MULT -3 * 5 with the macro defined: HI = 0xFFFFFFFF, LO = 0xFFFFFFF1. With the macro undefined: `busy` stays 0 and HI/LO are unchanged.
- `rd_hi` held high from the cycle after start: `stall` is high until the `done` cycle, then low, and `hi` shows the new result. A second `start` during busy is not accepted until IDLE.
- `rst_n` low at ITER step 10: `busy`, `hi`, `lo`, `done` = 0 immediately; the next DIVU 9 / 3 gives LO = 3, HI = 0.
